dcm_clkgen_program_interface: RTL and testbench

// Initiator side of the Spartan-6 DCM_CLKGEN dynamic M/D programming port (PROGEN/PROGDATA/PROGDONE).

---
 rtl/dcm_prog_pkg.sv | 24 ++
 rtl/dcm_prog_serializer.sv | 34 +++
 rtl/dcm_clkgen_program_interface.sv | 164 ++++++++++++++++
 tb/tb_dcm_clkgen_program_interface.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dcm_prog_pkg.sv
// Shared types and constants for the DCM_CLKGEN M/D programming port.
// Frames are sent LSB first: two prefix bits, then an 8-bit value.
package dcm_prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_D,
    GAP1,
    LOAD_M,
    GAP2,
    GO,
    WAIT_DONE
  } state_t;

  localparam logic [1:0] CMD_LOADD = 2'b01;
  localparam logic [1:0] CMD_LOADM = 2'b11;
  localparam int         FRAME_LEN = 10;

  // M=1 cannot be programmed, so the smallest legal multiplier is used instead.
  function automatic logic [7:0] clamp_mul(input logic [7:0] mul_m1);
    return (mul_m1 == 8'd0) ? 8'd1 : mul_m1;
  endfunction

endpackage

// File: rtl/dcm_prog_serializer.sv
// 10-bit frame shifter: loads {value,prefix}, presents bit 0 on a flop and
// shifts right with zero fill, so the line idles low once a frame is out.
module dcm_prog_serializer
  import dcm_prog_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [FRAME_LEN-1:0] word_i,
  output logic                 bit_o,
  output logic                 last_bit_o
);

  logic [FRAME_LEN-1:0] r_shift;
  logic [3:0]           r_count;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (load_i) begin
      r_shift <= word_i;
      r_count <= '0;
    end else if (shift_i) begin
      r_shift <= {1'b0, r_shift[FRAME_LEN-1:1]};
      r_count <= r_count + 4'd1;
    end
  end

  assign bit_o      = r_shift[0];
  assign last_bit_o = (r_count == 4'(FRAME_LEN - 1));

endmodule

// File: rtl/dcm_clkgen_program_interface.sv
// Initiator for the DCM_CLKGEN dynamic M/D port: sends LoadD, LoadM and GO
// frames, then waits (bounded) for PROGDONE before committing the new M/D.
module dcm_clkgen_program_interface
  import dcm_prog_pkg::*;
#(
  parameter logic [7:0]  DEFAULT_MUL_M1 = 8'd1,
  parameter logic [7:0]  DEFAULT_DIV_M1 = 8'd0,
  parameter int          GAP_CYCLES     = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] mul_i,
  input  logic [7:0] div_i,
  input  logic       load_i,
  output logic [7:0] mul_o,
  output logic [7:0] div_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_o,
  output logic       dcm_progen_o,
  output logic       dcm_progdata_o,
  input  logic       dcm_progdone_i
);

  state_t      r_state, w_state_nxt;
  logic        r_progen, w_progen_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        r_timeout, w_timeout_nxt;
  logic [7:0]  r_mul_o, w_mul_o_nxt;
  logic [7:0]  r_div_o, w_div_o_nxt;
  logic [15:0] r_count, w_count_nxt;
  logic [7:0]  r_mul, r_div;
  logic        w_latch;
  logic        w_ser_load, w_ser_shift, w_ser_bit, w_ser_last;
  logic [FRAME_LEN-1:0] w_ser_word;

  dcm_prog_serializer u_serializer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (w_ser_load),
    .shift_i    (w_ser_shift),
    .word_i     (w_ser_word),
    .bit_o      (w_ser_bit),
    .last_bit_o (w_ser_last)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_progen_nxt  = r_progen;
    w_busy_nxt    = r_busy;
    w_done_nxt    = r_done;
    w_timeout_nxt = r_timeout;
    w_mul_o_nxt   = r_mul_o;
    w_div_o_nxt   = r_div_o;
    w_count_nxt   = r_count;
    w_latch       = 1'b0;
    w_ser_load    = 1'b0;
    w_ser_shift   = 1'b0;
    w_ser_word    = {r_mul, CMD_LOADM};
    case (r_state)
      IDLE: begin
        if (load_i) begin
          // div_i goes straight into the frame; r_div is written on this same edge.
          w_latch       = 1'b1;
          w_ser_load    = 1'b1;
          w_ser_word    = {div_i, CMD_LOADD};
          w_state_nxt   = LOAD_D;
          w_progen_nxt  = 1'b1;
          w_busy_nxt    = 1'b1;
          w_done_nxt    = 1'b0;
          w_timeout_nxt = 1'b0;
        end
      end
      LOAD_D, LOAD_M: begin
        w_ser_shift = 1'b1;
        if (w_ser_last) begin
          w_state_nxt  = (r_state == LOAD_D) ? GAP1 : GAP2;
          w_progen_nxt = 1'b0;
          w_count_nxt  = '0;
        end
      end
      GAP1: begin
        if (r_count == 16'(GAP_CYCLES - 1)) begin
          w_ser_load   = 1'b1;
          w_state_nxt  = LOAD_M;
          w_progen_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count + 16'd1;
        end
      end
      GAP2: begin
        // Serializer has shifted out to zero, so GO carries progdata=0.
        if (r_count == 16'(GAP_CYCLES - 1)) begin
          w_state_nxt  = GO;
          w_progen_nxt = 1'b1;
        end else begin
          w_count_nxt = r_count + 16'd1;
        end
      end
      GO: begin
        w_state_nxt  = WAIT_DONE;
        w_progen_nxt = 1'b0;
        w_count_nxt  = '0;
      end
      WAIT_DONE: begin
        if (dcm_progdone_i) begin
          w_state_nxt = IDLE;
          w_mul_o_nxt = r_mul;
          w_div_o_nxt = r_div;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else if (r_count == TIMEOUT_CYCLES - 16'd1) begin
          w_state_nxt   = IDLE;
          w_timeout_nxt = 1'b1;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
        end else begin
          w_count_nxt = r_count + 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_progen  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b1;
      r_timeout <= 1'b0;
      r_mul_o   <= DEFAULT_MUL_M1;
      r_div_o   <= DEFAULT_DIV_M1;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_progen  <= w_progen_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_timeout <= w_timeout_nxt;
      r_mul_o   <= w_mul_o_nxt;
      r_div_o   <= w_div_o_nxt;
      r_count   <= w_count_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_latch) begin
      r_mul <= clamp_mul(mul_i);
      r_div <= div_i;
    end
  end

  assign mul_o          = r_mul_o;
  assign div_o          = r_div_o;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign timeout_o      = r_timeout;
  assign dcm_progen_o   = r_progen;
  assign dcm_progdata_o = w_ser_bit;

endmodule

// File: tb/tb_dcm_clkgen_program_interface.sv
// Bench for dcm_clkgen_program_interface: directed and random M/D requests
// compared cycle by cycle against an expected PROGEN/PROGDATA waveform.
module tb_dcm_clkgen_program_interface;

  localparam int GAP = 2;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] mul_i = 8'd0;
  logic [7:0] div_i = 8'd0;
  logic       load_i = 1'b0;
  logic       progdone_i = 1'b0;
  logic [7:0] mul_o, div_o;
  logic       busy_o, done_o, timeout_o, progen_o, progdata_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_mul = 8'd1;
  logic [7:0] exp_div = 8'd0;

  dcm_clkgen_program_interface #(
    .DEFAULT_MUL_M1 (8'd1),
    .DEFAULT_DIV_M1 (8'd0),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (16'(TMO))
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .mul_i          (mul_i),
    .div_i          (div_i),
    .load_i         (load_i),
    .mul_o          (mul_o),
    .div_o          (div_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .timeout_o      (timeout_o),
    .dcm_progen_o   (progen_o),
    .dcm_progdata_o (progdata_o),
    .dcm_progdone_i (progdone_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request at the current negedge and follows it to completion.
  // dly>0: PROGDONE pulses in the dly-th WAIT cycle; dly==0: PROGDONE never comes.
  task automatic request(input logic [7:0] m, input logic [7:0] d, input int dly, input bit inj);
    logic [1:0] q[$];
    logic [7:0] mc;
    int k;
    mc = (m == 8'd0) ? 8'd1 : m;
    q.push_back(2'b11);
    q.push_back(2'b10);
    for (int b = 0; b < 8; b++) q.push_back({1'b1, d[b]});
    for (int g = 0; g < GAP; g++) q.push_back(2'b00);
    q.push_back(2'b11);
    q.push_back(2'b11);
    for (int b = 0; b < 8; b++) q.push_back({1'b1, mc[b]});
    for (int g = 0; g < GAP; g++) q.push_back(2'b00);
    q.push_back(2'b10);

    mul_i = m; div_i = d; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) @(negedge clk);
      check("progen", {31'd0, progen_o}, {31'd0, q[i][1]});
      check("progdata", {31'd0, progdata_o}, {31'd0, q[i][0]});
      if (i == 0) begin
        check("busy_start", {31'd0, busy_o}, 32'd1);
        check("done_start", {31'd0, done_o}, 32'd0);
        check("timeout_clr", {31'd0, timeout_o}, 32'd0);
      end
      if (inj && i == 3) begin
        load_i = 1'b1; mul_i = 8'($urandom); div_i = 8'($urandom); progdone_i = 1'b1;
      end
      if (inj && i == 4) begin
        load_i = 1'b0; progdone_i = 1'b0;
      end
    end

    if (dly > 0) begin
      for (int j = 1; j <= dly; j++) begin
        @(negedge clk);
        check("wait_progen", {31'd0, progen_o}, 32'd0);
        check("wait_busy", {31'd0, busy_o}, 32'd1);
        if (inj && dly >= 3 && j == 1) begin
          load_i = 1'b1; mul_i = 8'($urandom); div_i = 8'($urandom);
        end
        if (j == 2) load_i = 1'b0;
      end
      progdone_i = 1'b1;
      @(negedge clk);
      progdone_i = 1'b0;
      exp_mul = mc;
      exp_div = d;
      check("done_after", {31'd0, done_o}, 32'd1);
      check("busy_after", {31'd0, busy_o}, 32'd0);
      check("timeout_ok", {31'd0, timeout_o}, 32'd0);
      check("idle_progen", {31'd0, progen_o}, 32'd0);
    end else begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
        if (inj && k == 1) begin
          load_i = 1'b1; mul_i = 8'($urandom); div_i = 8'($urandom);
        end
        if (k == 2) load_i = 1'b0;
      end while (!done_o && k < 3 * TMO);
      check("timeout_cycles", k, TMO + 1);
      check("timeout_flag", {31'd0, timeout_o}, 32'd1);
      check("busy_after_to", {31'd0, busy_o}, 32'd0);
    end
    check("mul_o", {24'd0, mul_o}, {24'd0, exp_mul});
    check("div_o", {24'd0, div_o}, {24'd0, exp_div});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rm, rd;
    int rdly;
    repeat (3) @(negedge clk);
    check("rst_progen", {31'd0, progen_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd1);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_mul", {24'd0, mul_o}, 32'd1);
    check("rst_div", {24'd0, div_o}, 32'd0);
    reset_i = 1'b0;
    @(negedge clk);
    check("post_rst_progen", {31'd0, progen_o}, 32'd0);
    check("post_rst_timeout", {31'd0, timeout_o}, 32'd0);

    request(8'd3, 8'd0, 5, 1'b0);
    request(8'd0, 8'd7, 3, 1'b0);
    request(8'd200, 8'd9, 0, 1'b0);
    request(8'd45, 8'd129, 4, 1'b1);
    request(8'd17, 8'd2, 0, 1'b1);
    request(8'd99, 8'd255, 1, 1'b0);

    for (int r = 0; r < 10; r++) begin
      rm = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      rd = 8'($urandom);
      rdly = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 10);
      request(rm, rd, rdly, 1'($urandom_range(0, 1)));
    end

    mul_i = 8'd77; div_i = 8'd5; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    repeat (14) @(negedge clk);
    check("mid_loadm_progen", {31'd0, progen_o}, 32'd1);
    #2 reset_i = 1'b1;
    #1;
    check("async_progen", {31'd0, progen_o}, 32'd0);
    check("async_progdata", {31'd0, progdata_o}, 32'd0);
    check("async_busy", {31'd0, busy_o}, 32'd0);
    check("async_done", {31'd0, done_o}, 32'd1);
    check("async_mul", {24'd0, mul_o}, 32'd1);
    check("async_div", {24'd0, div_o}, 32'd0);
    @(negedge clk);
    reset_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_no_resume", {31'd0, progen_o}, 32'd0);
    check("rst_idle_done", {31'd0, done_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
